// File: rtl/micro_flag_monitor_v_if.sv
// Sample/flag bundle between the flag source (master) and micro_flag_monitor_v (slave).
// CW must match the monitor's counter width.
interface micro_flag_monitor_v_if #(
    parameter int CW = 8
);
    logic          i_valid;
    logic          i_A;
    logic          i_L;
    logic          i_B;
    logic          i_clr;
    logic [1:0]    o_state;
    logic          o_change;
    logic          o_err;
    logic [CW-1:0] o_cnt_A;
    logic [CW-1:0] o_cnt_L;
    logic [CW-1:0] o_cnt_B;

    modport master (
        output i_valid, i_A, i_L, i_B, i_clr,
        input  o_state, o_change, o_err, o_cnt_A, o_cnt_L, o_cnt_B
    );

    modport slave (
        input  i_valid, i_A, i_L, i_B, i_clr,
        output o_state, o_change, o_err, o_cnt_A, o_cnt_L, o_cnt_B
    );
endinterface

// File: rtl/micro_flag_monitor_v.sv
// Debounces micro_v's A/L/B classification flags into a stable registered class,
// pulses on class changes, counts entries per class and latches multi-hot errors.
module micro_flag_monitor_v #(
    parameter int PERSIST = 3,
    parameter int CW      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    micro_flag_monitor_v_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_A    = 2'b01;
    localparam logic [1:0] ST_L    = 2'b10;
    localparam logic [1:0] ST_B    = 2'b11;

    localparam logic [3:0]    PERSIST_C = 4'(PERSIST);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    state_q,  state_d;
    logic          change_q, change_d;
    logic          err_q,    err_d;
    logic [CW-1:0] cnt_a_q,  cnt_a_d;
    logic [CW-1:0] cnt_l_q,  cnt_l_d;
    logic [CW-1:0] cnt_b_q,  cnt_b_d;
    logic [1:0]    cand_q,   cand_d;
    logic [3:0]    run_q,    run_d;

    logic [1:0] flag_sum_s;
    logic [1:0] sample_cls_s;
    logic       multi_s;
    logic       null_s;
    logic       adopt_s;

    // Classify the incoming flags: one-hot class, null, or multi-hot.
    always_comb begin
        flag_sum_s = {1'b0, bus.i_A} + {1'b0, bus.i_L} + {1'b0, bus.i_B};
        multi_s    = (flag_sum_s >= 2'd2);
        null_s     = (flag_sum_s == 2'd0);
        case ({bus.i_B, bus.i_L, bus.i_A})
            3'b001:  sample_cls_s = ST_A;
            3'b010:  sample_cls_s = ST_L;
            3'b100:  sample_cls_s = ST_B;
            default: sample_cls_s = ST_IDLE;
        endcase
    end

    // Next-state: debounce run, adoption, error latch and entry counters.
    always_comb begin
        state_d  = state_q;
        change_d = 1'b0;
        err_d    = err_q;
        cnt_a_d  = cnt_a_q;
        cnt_l_d  = cnt_l_q;
        cnt_b_d  = cnt_b_q;
        cand_d   = cand_q;
        run_d    = run_q;
        adopt_s  = 1'b0;

        if (bus.i_valid) begin
            if (multi_s) begin
                cand_d = ST_IDLE;
                run_d  = 4'd0;
                err_d  = 1'b1;
            end else if (null_s) begin
                cand_d = ST_IDLE;
                run_d  = 4'd0;
            end else if (sample_cls_s == cand_q) begin
                run_d = (run_q >= PERSIST_C) ? PERSIST_C : run_q + 4'd1;
            end else begin
                cand_d = sample_cls_s;
                run_d  = 4'd1;
            end

            // A saturated run of the current class never re-adopts.
            if ((run_d == PERSIST_C) && (cand_d != state_q)) begin
                adopt_s  = 1'b1;
                state_d  = cand_d;
                change_d = 1'b1;
            end else begin
                adopt_s  = 1'b0;
            end
        end else begin
            adopt_s = 1'b0;
        end

        // Clear beats the adoption increment; a coincident multi-hot still sets err.
        if (bus.i_clr) begin
            cnt_a_d = '0;
            cnt_l_d = '0;
            cnt_b_d = '0;
            err_d   = bus.i_valid & multi_s;
        end else if (adopt_s) begin
            case (state_d)
                ST_A:    cnt_a_d = (cnt_a_q == CNT_MAX) ? cnt_a_q : cnt_a_q + CNT_ONE;
                ST_L:    cnt_l_d = (cnt_l_q == CNT_MAX) ? cnt_l_q : cnt_l_q + CNT_ONE;
                ST_B:    cnt_b_d = (cnt_b_q == CNT_MAX) ? cnt_b_q : cnt_b_q + CNT_ONE;
                default: cnt_a_d = cnt_a_q;
            endcase
        end else begin
            cnt_a_d = cnt_a_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            change_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_a_q  <= '0;
            cnt_l_q  <= '0;
            cnt_b_q  <= '0;
            cand_q   <= ST_IDLE;
            run_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            change_q <= change_d;
            err_q    <= err_d;
            cnt_a_q  <= cnt_a_d;
            cnt_l_q  <= cnt_l_d;
            cnt_b_q  <= cnt_b_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
        end
    end

    assign bus.o_state  = state_q;
    assign bus.o_change = change_q;
    assign bus.o_err    = err_q;
    assign bus.o_cnt_A  = cnt_a_q;
    assign bus.o_cnt_L  = cnt_l_q;
    assign bus.o_cnt_B  = cnt_b_q;
endmodule

// File: tb/tb_micro_flag_monitor_v.sv
// Randomized and directed bench for micro_flag_monitor_v: three instances
// (PERSIST/CW = 3/8, 3/2, 1/8) share one stimulus stream and one history-based model.
module tb_micro_flag_monitor_v;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    micro_flag_monitor_v_if #(.CW(8)) if0 ();
    micro_flag_monitor_v_if #(.CW(2)) if1 ();
    micro_flag_monitor_v_if #(.CW(8)) if2 ();

    micro_flag_monitor_v #(.PERSIST(3), .CW(8)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
    micro_flag_monitor_v #(.PERSIST(3), .CW(2)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
    micro_flag_monitor_v #(.PERSIST(1), .CW(8)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: class history of valid samples (0 = null/multi-hot, 1=A, 2=L, 3=B).
    int hist[$];
    int m_persist[3] = '{3, 3, 1};
    int m_cmax[3]    = '{255, 3, 255};
    int m_state[3];
    int m_change[3];
    int m_err[3];
    int m_cnt[3][3];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input bit a, input bit l, input bit b,
                              input bit c, input bit r);
        int nflags;
        int cls;
        bit all_same;
        nflags = int'(a) + int'(l) + int'(b);
        cls = (nflags != 1) ? 0 : (a ? 1 : (l ? 2 : 3));
        if (r) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                m_state[i] = 0; m_change[i] = 0; m_err[i] = 0;
                for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
            end
            return;
        end
        if (v) begin
            hist.push_back(cls);
            if (hist.size() > 16) void'(hist.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            bit adopt;
            adopt = 1'b0;
            if (v && cls != 0 && hist.size() >= m_persist[i] && cls != m_state[i]) begin
                all_same = 1'b1;
                for (int j = 0; j < m_persist[i]; j++)
                    if (hist[hist.size() - 1 - j] != cls) all_same = 1'b0;
                adopt = all_same;
            end
            m_change[i] = adopt ? 1 : 0;
            if (adopt) m_state[i] = cls;
            if (v && nflags >= 2) m_err[i] = 1;
            else if (c) m_err[i] = 0;
            if (c) begin
                for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
            end else if (adopt && m_cnt[i][cls-1] < m_cmax[i]) begin
                m_cnt[i][cls-1]++;
            end
        end
    endtask

    task automatic check_inst(input int i, input int st, input int ch, input int er,
                              input int ca, input int cl, input int cb);
        check_eq($sformatf("u%0d.state", i), st, m_state[i]);
        check_eq($sformatf("u%0d.change", i), ch, m_change[i]);
        check_eq($sformatf("u%0d.err", i), er, m_err[i]);
        check_eq($sformatf("u%0d.cnt_A", i), ca, m_cnt[i][0]);
        check_eq($sformatf("u%0d.cnt_L", i), cl, m_cnt[i][1]);
        check_eq($sformatf("u%0d.cnt_B", i), cb, m_cnt[i][2]);
    endtask

    // One clock: drive inputs, let the edge happen, then compare all instances.
    task automatic cyc(input bit v, input bit a, input bit l, input bit b,
                       input bit c, input bit r);
        rst = r;
        if0.i_valid = v; if0.i_A = a; if0.i_L = l; if0.i_B = b; if0.i_clr = c;
        if1.i_valid = v; if1.i_A = a; if1.i_L = l; if1.i_B = b; if1.i_clr = c;
        if2.i_valid = v; if2.i_A = a; if2.i_L = l; if2.i_B = b; if2.i_clr = c;
        @(posedge clk);
        #1;
        model_step(v, a, l, b, c, r);
        check_inst(0, int'(if0.o_state), int'(if0.o_change), int'(if0.o_err),
                   int'(if0.o_cnt_A), int'(if0.o_cnt_L), int'(if0.o_cnt_B));
        check_inst(1, int'(if1.o_state), int'(if1.o_change), int'(if1.o_err),
                   int'(if1.o_cnt_A), int'(if1.o_cnt_L), int'(if1.o_cnt_B));
        check_inst(2, int'(if2.o_state), int'(if2.o_change), int'(if2.o_err),
                   int'(if2.o_cnt_A), int'(if2.o_cnt_L), int'(if2.o_cnt_B));
    endtask

    task automatic smp(input int cls);
        cyc(1'b1, cls == 1, cls == 2, cls == 3, 1'b0, 1'b0);
    endtask

    initial begin
        int changes;
        bit v, a, l, b, c, r;
        int k;

        // Reset state and basic adoption after three A samples.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("reset_state", int'(if0.o_state), 0);
        check_eq("reset_cnt_A", int'(if0.o_cnt_A), 0);
        smp(1);
        check_eq("p1_first_sample", int'(if2.o_state), 1);
        smp(1);
        check_eq("before_adopt", int'(if0.o_state), 0);
        smp(1);
        check_eq("adopt_A_state", int'(if0.o_state), 1);
        check_eq("adopt_A_change", int'(if0.o_change), 1);
        check_eq("adopt_A_cnt", int'(if0.o_cnt_A), 1);
        smp(1);
        check_eq("change_one_cycle", int'(if0.o_change), 0);
        check_eq("no_readopt_cnt", int'(if0.o_cnt_A), 1);

        // Invalid cycles do not break a run.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        smp(1); smp(1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("gap_hold", int'(if0.o_state), 0);
        smp(1);
        check_eq("gap_adopt", int'(if0.o_state), 1);

        // L,L,B,B,B from A.
        smp(2); smp(2); smp(3); smp(3);
        check_eq("lb_mid", int'(if0.o_state), 1);
        smp(3);
        check_eq("lb_state_B", int'(if0.o_state), 3);
        check_eq("lb_cnt_B", int'(if0.o_cnt_B), 1);
        check_eq("lb_cnt_L", int'(if0.o_cnt_L), 0);

        // Multi-hot error is sticky; clear wipes error and counters only.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("multi_err", int'(if0.o_err), 1);
        smp(1); smp(2);
        check_eq("err_sticky", int'(if0.o_err), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("clr_err", int'(if0.o_err), 0);
        check_eq("clr_cnt_B", int'(if0.o_cnt_B), 0);
        check_eq("clr_state_kept", int'(if0.o_state), 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("set_beats_clr", int'(if0.o_err), 1);

        // Saturation with CW=2.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        changes = 0;
        for (int rnd = 0; rnd < 10; rnd++) begin
            for (int j = 0; j < 3; j++) begin smp(1); changes += int'(if1.o_change); end
            for (int j = 0; j < 3; j++) begin smp(2); changes += int'(if1.o_change); end
        end
        check_eq("sat_cnt_A", int'(if1.o_cnt_A), 3);
        check_eq("sat_cnt_L", int'(if1.o_cnt_L), 3);
        check_eq("sat_changes", changes, 20);
        check_eq("wide_cnt_A", int'(if0.o_cnt_A), 10);

        // Reset mid-run discards the partial run.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        smp(1); smp(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        smp(1);
        check_eq("rst_run_state", int'(if0.o_state), 0);
        smp(1);
        check_eq("rst_run_state2", int'(if0.o_state), 0);
        smp(1);
        check_eq("rst_run_adopt", int'(if0.o_state), 1);

        // Randomized phase, biased toward repeated samples so adoptions occur.
        a = 1'b1; l = 1'b0; b = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) >= 70) begin
                k = $urandom_range(0, 9);
                if (k == 0) begin
                    a = 1'b0; l = 1'b0; b = 1'b0;
                end else if (k == 1) begin
                    a = 1'b1; l = 1'b1; b = 1'b1;
                    case ($urandom_range(0, 3))
                        0: a = 1'b0;
                        1: l = 1'b0;
                        2: b = 1'b0;
                        default: ;
                    endcase
                end else begin
                    k = $urandom_range(0, 2);
                    a = (k == 0); l = (k == 1); b = (k == 2);
                end
            end
            c = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 199) == 0);
            cyc(v, a, l, b, c, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
